// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: reset level,
// per-stage stall encodings and divider sequencer state codes.
package pipe_ctrl_pkg;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

  // Bit i holds stage i: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [5:0] STALL_EX       = 6'b001111;
  localparam logic [5:0] STALL_MEM      = 6'b011111;

  localparam int DIV_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// Divider handshake sequencer: start/cancel pulses, EX stall request and a
// sticky watchdog that flags a divider which never answers.
module pipe_ctrl_div_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_i,
  input  logic div_req_i,
  input  logic div_done_i,
  input  logic mem_stall_i,
  input  logic excp_i,
  output logic ex_stall_o,
  output logic div_start_o,
  output logic div_cancel_o,
  output logic div_timeout_o
);

  localparam int              CW       = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV_TIMEOUT - 1);

  div_state_e    state_q;
  logic [CW-1:0] div_cnt_q;
  logic          timeout_q;
  logic          rst_n_act;

  assign rst_n_act = (rst_i != RST_ENABLE);

  // Pulses are decided combinationally so the divider sees them in the decision cycle.
  assign ex_stall_o   = rst_n_act &&
                        (((state_q == DIV_IDLE) && div_req_i) || (state_q == DIV_BUSY));
  assign div_start_o  = rst_n_act && (state_q == DIV_IDLE) && div_req_i &&
                        !excp_i && !mem_stall_i;
  assign div_cancel_o = rst_n_act && (state_q == DIV_BUSY) && excp_i;
  assign div_timeout_o = timeout_q;

  always_ff @(posedge clk) begin
    if (rst_i == RST_ENABLE) begin
      state_q   <= DIV_IDLE;
      div_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_start_o) begin
            state_q   <= DIV_BUSY;
            div_cnt_q <= '0;
          end
        end
        DIV_BUSY: begin
          if (div_cnt_q != CNT_MAX) div_cnt_q <= div_cnt_q + CW'(1);
          if (div_cnt_q == CNT_LAST) timeout_q <= 1'b1;
          if (excp_i)          state_q <= DIV_IDLE;
          else if (div_done_i) state_q <= DIV_DONE;
        end
        DIV_DONE: begin
          // Hold the result while MEM is stuck so ex_mem still captures it.
          if (excp_i || !mem_stall_i) state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: load-use detection, stall priority mux,
// exception redirect and a stall-cycle performance counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read,
  input  logic [4:0]       id_reg1_addr,
  input  logic             id_reg2_read,
  input  logic [4:0]       id_reg2_addr,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wd,
  input  logic             ex_wreg,
  input  logic             ex_div_req,
  input  logic             div_done,
  input  logic             mem_stallreq,
  input  logic             excp_valid,
  input  logic [31:0]      excp_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             div_start,
  output logic             div_cancel,
  output logic             div_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ex_stall;
  logic             load_use;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  pipe_ctrl_div_seq #(
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) u_div_seq (
    .clk          (clk),
    .rst_i        (rst),
    .div_req_i    (ex_div_req),
    .div_done_i   (div_done),
    .mem_stall_i  (mem_stallreq),
    .excp_i       (excp_valid),
    .ex_stall_o   (ex_stall),
    .div_start_o  (div_start),
    .div_cancel_o (div_cancel),
    .div_timeout_o(div_timeout)
  );

  assign load_use = ex_is_load && ex_wreg && (ex_wd != NOP_REG_ADDR) &&
                    ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                     (id_reg2_read && (id_reg2_addr == ex_wd)));

  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = ZERO_WORD;
    if (rst != RST_ENABLE) begin
      if (excp_valid) begin
        flush  = 1'b1;
        new_pc = excp_pc;
      end else if (mem_stallreq) begin
        stall = STALL_MEM;
      end else if (ex_stall) begin
        stall = STALL_EX;
      end else if (load_use) begin
        stall = STALL_LOAD_USE;
      end
    end
  end

  assign stall_cnt_d = stall[0] ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) stall_cnt_q <= '0;
    else                   stall_cnt_q <= stall_cnt_d;
  end

endmodule
